// File: rtl/ibex_pkg.sv
// Shared types for the fetch aligner: aligner states and the RV32 base opcodes
// produced by the compressed-instruction expander.
package ibex_pkg;

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    HALF    = 2'd1,
    SKIP    = 2'd2
  } align_state_e;

  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;
  localparam logic [6:0] OPCODE_JAL    = 7'h6f;

endpackage

// File: rtl/ibex_c_expand.sv
// RV32C halfword to RV32I expander; purely combinational (0 cycles), no flow control.
// Flags reserved/illegal compressed encodings; quadrant 3 is passed through as legal.
module ibex_c_expand
  import ibex_pkg::*;
(
  input  logic [15:0] instr_i,
  output logic [31:0] instr_o,
  output logic        illegal_o
);

  always_comb begin
    instr_o   = {16'h0000, instr_i};
    illegal_o = 1'b0;
    case (instr_i[1:0])
      2'b00: begin
        case (instr_i[15:13])
          3'b000: begin
            instr_o   = {2'b00, instr_i[10:7], instr_i[12:11], instr_i[5], instr_i[6], 2'b00,
                         5'h02, 3'b000, 2'b01, instr_i[4:2], OPCODE_OP_IMM};
            illegal_o = (instr_i[12:5] == 8'h00);
          end
          3'b010: instr_o = {5'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00, 2'b01,
                             instr_i[9:7], 3'b010, 2'b01, instr_i[4:2], OPCODE_LOAD};
          3'b110: instr_o = {5'b0, instr_i[5], instr_i[12], 2'b01, instr_i[4:2], 2'b01,
                             instr_i[9:7], 3'b010, instr_i[11:10], instr_i[6], 2'b00, OPCODE_STORE};
          default: illegal_o = 1'b1;
        endcase
      end
      2'b01: begin
        case (instr_i[15:13])
          3'b000: instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], instr_i[11:7], 3'b000,
                             instr_i[11:7], OPCODE_OP_IMM};
          3'b010: instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], 5'h00, 3'b000,
                             instr_i[11:7], OPCODE_OP_IMM};
          3'b001, 3'b101: instr_o = {instr_i[12], instr_i[8], instr_i[10:9], instr_i[6], instr_i[7],
                                     instr_i[2], instr_i[11], instr_i[5:3], {9{instr_i[12]}},
                                     4'b0000, ~instr_i[15], OPCODE_JAL};
          3'b011: begin
            // rd == x2 selects c.addi16sp, anything else is c.lui
            if (instr_i[11:7] == 5'h02) begin
              instr_o = {{3{instr_i[12]}}, instr_i[4:3], instr_i[5], instr_i[2], instr_i[6], 4'b0000,
                         5'h02, 3'b000, 5'h02, OPCODE_OP_IMM};
            end else begin
              instr_o = {{15{instr_i[12]}}, instr_i[6:2], instr_i[11:7], OPCODE_LUI};
            end
            illegal_o = ({instr_i[12], instr_i[6:2]} == 6'h00);
          end
          3'b100: begin
            case (instr_i[11:10])
              2'b00, 2'b01: begin
                instr_o   = {1'b0, instr_i[10], 5'b0, instr_i[6:2], 2'b01, instr_i[9:7], 3'b101,
                             2'b01, instr_i[9:7], OPCODE_OP_IMM};
                illegal_o = instr_i[12];
              end
              2'b10: instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], 2'b01, instr_i[9:7],
                                3'b111, 2'b01, instr_i[9:7], OPCODE_OP_IMM};
              default: begin
                instr_o   = {1'b0, (instr_i[6:5] == 2'b00), 5'b0, 2'b01, instr_i[4:2], 2'b01,
                             instr_i[9:7],
                             (instr_i[6:5] == 2'b00) ? 3'b000 :
                             (instr_i[6] ? {2'b11, instr_i[5]} : 3'b100),
                             2'b01, instr_i[9:7], OPCODE_OP};
                illegal_o = instr_i[12];
              end
            endcase
          end
          default: instr_o = {{4{instr_i[12]}}, instr_i[6:5], instr_i[2], 5'h00, 2'b01,
                              instr_i[9:7], 2'b00, instr_i[13], instr_i[11:10], instr_i[4:3],
                              instr_i[12], OPCODE_BRANCH};
        endcase
      end
      2'b10: begin
        case (instr_i[15:13])
          3'b000: begin
            instr_o   = {7'b0, instr_i[6:2], instr_i[11:7], 3'b001, instr_i[11:7], OPCODE_OP_IMM};
            illegal_o = instr_i[12];
          end
          3'b010: begin
            instr_o   = {4'b0, instr_i[3:2], instr_i[12], instr_i[6:4], 2'b00, 5'h02, 3'b010,
                         instr_i[11:7], OPCODE_LOAD};
            illegal_o = (instr_i[11:7] == 5'h00);
          end
          3'b100: begin
            if (instr_i[6:2] != 5'h00) begin
              instr_o = {7'b0, instr_i[6:2], instr_i[12] ? instr_i[11:7] : 5'h00, 3'b000,
                         instr_i[11:7], OPCODE_OP};
            end else if (instr_i[12] && (instr_i[11:7] == 5'h00)) begin
              instr_o = 32'h0010_0073;
            end else begin
              instr_o   = {12'h000, instr_i[11:7], 3'b000, 4'b0000, instr_i[12], OPCODE_JALR};
              illegal_o = ~instr_i[12] & (instr_i[11:7] == 5'h00);
            end
          end
          3'b110: instr_o = {4'b0, instr_i[8:7], instr_i[12], instr_i[6:2], 5'h02, 3'b010,
                             instr_i[11:9], 2'b00, OPCODE_STORE};
          default: illegal_o = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ibex_fetch_align_expander.sv
// Realigns word fetches into 16/32-bit instructions and expands RVC; 0-cycle output latency.
// Words are consumed only when the emitted instruction takes them and out_ready_i is high.
module ibex_fetch_align_expander
  import ibex_pkg::*;
#(
  parameter bit          RVC      = 1'b1,
  parameter logic [31:0] BootAddr = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        out_is_compressed_o,
  output logic        out_illegal_o,
  output logic        out_err_o
);

  align_state_e r_state;
  logic [31:0]  r_pc;
  logic [15:0]  r_hw;
  logic         r_hw_err;

  align_state_e w_next_state;
  logic [15:0]  w_exp_in;
  logic [31:0]  w_exp_instr;
  logic         w_exp_ill;
  logic [31:0]  w_inc;
  logic [31:0]  w_flush_pc;
  logic         w_valid;
  logic         w_consume;
  logic         w_load_hw;
  logic         w_fire;

  assign w_exp_in = (r_state == ALIGNED) ? in_rdata_i[15:0] : r_hw;

  ibex_c_expand u_c_expand (
    .instr_i   (w_exp_in),
    .instr_o   (w_exp_instr),
    .illegal_o (w_exp_ill)
  );

  always_comb begin
    w_valid             = 1'b0;
    w_consume           = 1'b0;
    w_load_hw           = 1'b0;
    w_inc               = 32'd4;
    w_next_state        = r_state;
    out_instr_o         = in_rdata_i;
    out_is_compressed_o = 1'b0;
    out_illegal_o       = 1'b0;
    out_err_o           = in_err_i;
    case (r_state)
      ALIGNED: begin
        w_valid   = in_valid_i;
        w_consume = 1'b1;
        if (in_rdata_i[1:0] != 2'b11) begin
          if (RVC) begin
            out_instr_o         = w_exp_instr;
            out_is_compressed_o = 1'b1;
            out_illegal_o       = w_exp_ill;
            w_inc               = 32'd2;
            w_next_state        = HALF;
            w_load_hw           = 1'b1;
          end else begin
            out_illegal_o = 1'b1;
          end
        end
      end
      HALF: begin
        if (r_hw[1:0] != 2'b11) begin
          w_valid             = 1'b1;
          out_instr_o         = w_exp_instr;
          out_is_compressed_o = 1'b1;
          out_illegal_o       = w_exp_ill;
          out_err_o           = r_hw_err;
          w_inc               = 32'd2;
          w_next_state        = ALIGNED;
        end else begin
          // 32-bit instruction straddling the buffered half and the next word
          w_valid     = in_valid_i;
          w_consume   = 1'b1;
          w_load_hw   = 1'b1;
          out_instr_o = {in_rdata_i[15:0], r_hw};
          out_err_o   = r_hw_err | in_err_i;
        end
      end
      default: ;
    endcase
  end

  assign out_valid_o = rst_ni & ~flush_i & w_valid;
  assign in_ready_o  = rst_ni & (flush_i | (r_state == SKIP) | (w_consume & out_ready_i));
  assign out_pc_o    = r_pc;
  assign w_fire      = out_valid_o & out_ready_i;
  assign w_flush_pc  = flush_pc_i & (RVC ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ALIGNED;
      r_pc     <= BootAddr;
      r_hw     <= 16'h0000;
      r_hw_err <= 1'b0;
    end else if (flush_i) begin
      r_pc     <= w_flush_pc;
      r_state  <= w_flush_pc[1] ? SKIP : ALIGNED;
      r_hw     <= 16'h0000;
      r_hw_err <= 1'b0;
    end else if (w_fire) begin
      r_pc    <= r_pc + w_inc;
      r_state <= w_next_state;
      if (w_load_hw) begin
        r_hw     <= in_rdata_i[31:16];
        r_hw_err <= in_err_i;
      end
    end else if ((r_state == SKIP) && in_valid_i) begin
      r_hw     <= in_rdata_i[31:16];
      r_hw_err <= in_err_i;
      r_state  <= HALF;
    end
  end

endmodule

// File: doc/ibex_fetch_align_expander.md
IBEX_FETCH_ALIGN_EXPANDER -- requirements
Module: ibex_fetch_align_expander

Interface
REQ-001: The module SHALL have parameter RVC, bit, default 1, meaning compressed (RV32C) support is enabled.
REQ-002: The module SHALL have parameter BootAddr, logic [31:0], default 32'h0000_0080, meaning the PC value at reset.
REQ-003: The module SHALL have port clk_i, input, 1 bit, the single clock.
REQ-004: The module SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-005: The module SHALL have port flush_i, input, 1 bit, which discards buffered state and redirects the PC.
REQ-006: The module SHALL have port flush_pc_i, input, 32 bits, the redirect target; bit 0 is ignored.
REQ-007: The module SHALL have ports in_valid_i (input, 1), in_ready_o (output, 1), in_rdata_i (input, 32) and in_err_i (input, 1), carrying word-aligned fetch words in address order.
REQ-008: The module SHALL have ports out_valid_o (output, 1) and out_ready_i (input, 1) forming the instruction handshake.
REQ-009: The module SHALL have ports out_instr_o (32), out_pc_o (32), out_is_compressed_o (1), out_illegal_o (1) and out_err_o (1), all outputs.

Function
REQ-010: The module SHALL implement a state machine with states ALIGNED, HALF (16-bit buffer hw_q holds the halfword at pc_q) and SKIP (discard the low half of the next word).
REQ-011: In ALIGNED with in_valid_i and in_rdata_i[1:0]==2'b11, the module SHALL emit in_rdata_i unchanged, not compressed; on handshake consume the word, pc += 4 and stay in ALIGNED.
REQ-012: In ALIGNED with in_rdata_i[1:0]!=2'b11, the module SHALL emit the expansion of in_rdata_i[15:0]; on handshake consume the word, hw_q <= in_rdata_i[31:16], pc += 2 and move to HALF.
REQ-013: In HALF with hw_q[1:0]!=2'b11, the module SHALL emit the expansion of hw_q independent of in_valid_i, with in_ready_o=0; on handshake pc += 2 and move to ALIGNED.
REQ-014: In HALF with hw_q[1:0]==2'b11, the module SHALL require in_valid_i and emit {in_rdata_i[15:0], hw_q}; on handshake consume the word, hw_q <= in_rdata_i[31:16], pc += 4 and stay in HALF.
REQ-015: In SKIP with in_valid_i, the module SHALL assert in_ready_o, load hw_q <= in_rdata_i[31:16] and move to HALF, with no output emitted.
REQ-016: The module SHALL assert in_ready_o only when the current emit consumes the input word, and then it SHALL equal out_ready_i.
REQ-017: Output data SHALL be combinational from in_rdata_i or hw_q, giving 0-cycle latency, and SHALL stay stable while out_valid_o=1 and out_ready_i=0.
REQ-018: out_pc_o SHALL equal pc_q, which wraps modulo 2^32.
REQ-019: out_illegal_o SHALL be 1 for reserved or illegal compressed encodings, with expansion rules per the RV32C ISA; it SHALL be 0 for 32-bit instructions.
REQ-020: out_err_o SHALL be the in_err_i of every word contributing bits to the instruction; hw_err_q SHALL be stored alongside hw_q.
REQ-021: flush_i SHALL take priority over all other activity.
  - In the flush cycle: out_valid_o=0, in_ready_o=1 (the word is dropped), no handshake counted.
  - Next cycle: pc_q = {flush_pc_i[31:1],1'b0}; state = SKIP if flush_pc_i[1] else ALIGNED; hw_q invalid.
REQ-022: When RVC=0, the module SHALL stay permanently in ALIGNED, treat a word with [1:0]!=2'b11 as illegal (out_illegal_o=1, pc += 4), and treat flush_pc_i[1] as 0.

Reset
REQ-023: On reset assertion, the module SHALL asynchronously set state=ALIGNED, pc_q=BootAddr, hw_q=0 and hw_err_q=0.
REQ-024: While rst_ni=0, out_valid_o and in_ready_o SHALL be 0.
REQ-025: Reset asserted mid-instruction SHALL discard any buffered halfword without producing an output.

Structure
REQ-026: The state enum and OPCODE_* constants SHALL live in ibex_pkg.
REQ-027: The halfword-to-RV32 expansion SHALL be a purely combinational sub-module, ibex_c_expand (inputs: 16-bit halfword; outputs: 32-bit instr, illegal).
REQ-028: The RTL SHALL contain only one expander instance, fed by a mux of in_rdata_i[15:0] and hw_q.

Verification
REQ-029: Word 0x00a00093 @0x80 -> out 0x00a00093, pc 0x80, compressed=0; next pc 0x84.
REQ-030: Word 0x45054501 @0x100 -> out 0x00000513 @0x100 with in_ready=1, then 0x00100513 @0x102 with in_ready=0; both compressed=1.
REQ-031: Words 0x00934501, 0x000000a0 @0x200 -> out 0x00000513 @0x200, then 0x00a00093 @0x202, compressed=0.
REQ-032: Flush to 0x302, then word 0x45050001 -> low half dropped; first out 0x00100513 @0x302.
REQ-033: Word 0x00000000 -> out_illegal_o=1, compressed=1; in the spanning case of REQ-031 with in_err_i=1 on word 2 -> the second instruction has out_err_o=1.
REQ-034: out_ready_i=0 for 3 cycles mid-stream -> outputs stable, in_ready_o=0, pc held; flush asserted during the stall -> no handshake counted.
